i2c_frame_timer: RTL and testbench

I2C_FRAME_TIMER -- requirements
Module: i2c_frame_timer

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/flex_counter.sv | 28 ++
 rtl/i2c_frame_timer.sv | 174 +++++++++++++++++
 tb/tb_i2c_frame_timer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C frame timer: FSM state encoding,
// default parameter values and a counter-width helper.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA      = 2'd1,
        ST_BYTE_DONE = 2'd2,
        ST_ACK       = 2'd3
    } i2c_state_e;

    localparam int DEF_DATA_BITS      = 8;
    localparam int DEF_BYTE_CNT_BITS  = 8;
    localparam int DEF_TIMEOUT_CYCLES = 10000;

    // Width needed to hold values 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Parametrised up-counter with a synchronous active-high clear that
// takes priority over the count enable.
`timescale 1ns/1ps
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_count_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable; otherwise count up by one or hold.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/i2c_frame_timer.sv
// I2C frame timer: tracks data bits, the ACK bit and completed frames
// from pre-detected SCL edge / START / STOP pulses, and aborts a transfer
// when SCL stays quiet for TIMEOUT_CYCLES clocks.
`timescale 1ns/1ps
module i2c_frame_timer
    import i2c_pkg::*;
#(
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int BYTE_CNT_BITS  = DEF_BYTE_CNT_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rising_edge_found,
    input  logic                           falling_edge_found,
    input  logic                           start_found,
    input  logic                           stop_found,
    output logic                           byte_received,
    output logic                           ack_prep,
    output logic                           check_ack,
    output logic                           ack_done,
    output logic [$clog2(DATA_BITS+1)-1:0] bit_index,
    output logic [BYTE_CNT_BITS-1:0]       byte_count,
    output logic                           busy,
    output logic                           timeout
);

    localparam int BI_W = $clog2(DATA_BITS + 1);
    localparam int IC_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [BI_W-1:0] LAST_BIT = BI_W'(DATA_BITS - 1);
    localparam logic [IC_W-1:0] TO_LAST  = IC_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic            TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [BYTE_CNT_BITS-1:0] BC_MAX = '1;

    i2c_state_e r_state;
    i2c_state_e w_state_next;

    logic                     r_byte_received;
    logic                     r_ack_prep;
    logic                     r_check_ack;
    logic                     r_ack_done;
    logic                     r_busy;
    logic                     r_timeout;
    logic [BYTE_CNT_BITS-1:0] r_byte_count;

    logic            w_rise;
    logic            w_fall;
    logic            w_scl_edge;
    logic            w_timeout_hit;
    logic            w_ack_prep;
    logic            w_ack_done;
    logic            w_bit_clr;
    logic            w_bit_inc;
    logic            w_idle_clr;
    logic            w_idle_en;
    logic [BI_W-1:0] w_bit_index;
    logic [IC_W-1:0] w_idle_cnt;

    // Simultaneous rising and falling pulses cancel each other out.
    assign w_rise     = rising_edge_found & ~falling_edge_found;
    assign w_fall     = falling_edge_found & ~rising_edge_found;
    assign w_scl_edge = rising_edge_found | falling_edge_found;

    // The counter reaches TIMEOUT_CYCLES on this clock; STOP/START outrank it.
    assign w_timeout_hit = TO_EN && (r_state != ST_IDLE) && (w_idle_cnt == TO_LAST)
                           && !stop_found && !start_found;

    assign w_bit_clr  = rst | stop_found | start_found | w_timeout_hit | w_ack_done;
    assign w_bit_inc  = (r_state == ST_DATA) & w_rise;
    assign w_idle_clr = rst | w_scl_edge | start_found | stop_found | w_timeout_hit;
    assign w_idle_en  = TO_EN & (r_state != ST_IDLE);

    flex_counter #(.WIDTH(BI_W)) u_bit_cnt (
        .clk        (clk),
        .i_clear    (w_bit_clr),
        .i_count_en (w_bit_inc),
        .o_count    (w_bit_index)
    );

    flex_counter #(.WIDTH(IC_W)) u_idle_cnt (
        .clk        (clk),
        .i_clear    (w_idle_clr),
        .i_count_en (w_idle_en),
        .o_count    (w_idle_cnt)
    );

    // Next-state and pulse decode with STOP > START > timeout > SCL edges.
    always_comb begin
        w_state_next = r_state;
        w_ack_prep   = 1'b0;
        w_ack_done   = 1'b0;
        if (stop_found) begin
            w_state_next = ST_IDLE;
        end else if (start_found) begin
            w_state_next = ST_DATA;
        end else if (w_timeout_hit) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_IDLE;
                end
                ST_DATA: begin
                    if (w_rise && (w_bit_index == LAST_BIT)) begin
                        w_state_next = ST_BYTE_DONE;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
                ST_BYTE_DONE: begin
                    if (w_fall) begin
                        w_state_next = ST_ACK;
                        w_ack_prep   = 1'b1;
                    end else begin
                        w_state_next = ST_BYTE_DONE;
                    end
                end
                ST_ACK: begin
                    // Rising edges inside the ACK bit are deliberately ignored.
                    if (w_fall) begin
                        w_state_next = ST_DATA;
                        w_ack_done   = 1'b1;
                    end else begin
                        w_state_next = ST_ACK;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus all registered outputs; levels decode the new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_byte_received <= 1'b0;
            r_ack_prep      <= 1'b0;
            r_check_ack     <= 1'b0;
            r_ack_done      <= 1'b0;
            r_busy          <= 1'b0;
            r_timeout       <= 1'b0;
            r_byte_count    <= '0;
        end else begin
            r_state         <= w_state_next;
            r_byte_received <= (w_state_next == ST_BYTE_DONE);
            r_check_ack     <= (w_state_next == ST_ACK);
            r_busy          <= (w_state_next != ST_IDLE);
            r_ack_prep      <= w_ack_prep;
            r_ack_done      <= w_ack_done;
            r_timeout       <= w_timeout_hit;
            if (stop_found) begin
                r_byte_count <= r_byte_count;
            end else if (start_found) begin
                r_byte_count <= '0;
            end else if (w_ack_done && (r_byte_count != BC_MAX)) begin
                r_byte_count <= r_byte_count + BYTE_CNT_BITS'(1);
            end else begin
                r_byte_count <= r_byte_count;
            end
        end
    end

    assign byte_received = r_byte_received;
    assign ack_prep      = r_ack_prep;
    assign check_ack     = r_check_ack;
    assign ack_done      = r_ack_done;
    assign busy          = r_busy;
    assign timeout       = r_timeout;
    assign byte_count    = r_byte_count;
    assign bit_index     = w_bit_index;

endmodule

// File: tb/tb_i2c_frame_timer.sv
// Directed bench for i2c_frame_timer: one default-parameter instance and
// one small instance (4 data bits, 2-bit byte count, 20-cycle timeout)
// share the same stimulus; each check targets the relevant instance.
`timescale 1ns/1ps
module tb_i2c_frame_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rise = 1'b0;
    logic fall = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;

    logic       d_byte_received, d_ack_prep, d_check_ack, d_ack_done, d_busy, d_timeout;
    logic [3:0] d_bit_index;
    logic [7:0] d_byte_count;
    logic       s_byte_received, s_ack_prep, s_check_ack, s_ack_done, s_busy, s_timeout;
    logic [2:0] s_bit_index;
    logic [1:0] s_byte_count;

    int n_total = 0;
    int n_pass  = 0;
    int d_prep_cnt = 0;
    int s_prep_cnt = 0;
    int mark;

    always #5 clk = ~clk;

    i2c_frame_timer u_d (
        .clk(clk), .rst(rst),
        .rising_edge_found(rise), .falling_edge_found(fall),
        .start_found(start), .stop_found(stop),
        .byte_received(d_byte_received), .ack_prep(d_ack_prep),
        .check_ack(d_check_ack), .ack_done(d_ack_done),
        .bit_index(d_bit_index), .byte_count(d_byte_count),
        .busy(d_busy), .timeout(d_timeout)
    );

    i2c_frame_timer #(.DATA_BITS(4), .BYTE_CNT_BITS(2), .TIMEOUT_CYCLES(20)) u_s (
        .clk(clk), .rst(rst),
        .rising_edge_found(rise), .falling_edge_found(fall),
        .start_found(start), .stop_found(stop),
        .byte_received(s_byte_received), .ack_prep(s_ack_prep),
        .check_ack(s_check_ack), .ack_done(s_ack_done),
        .bit_index(s_bit_index), .byte_count(s_byte_count),
        .busy(s_busy), .timeout(s_timeout)
    );

    // Count ack_prep pulses of each instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (d_ack_prep) d_prep_cnt <= d_prep_cnt + 1;
        if (s_ack_prep) s_prep_cnt <= s_prep_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Present one cycle of input pulses; return #1 after the sampling edge.
    task automatic step(input logic r, input logic f, input logic s, input logic p);
        rise = r; fall = f; start = s; stop = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Full default-instance frame: 8 data bits, then the ACK bit.
    task automatic d_frame();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Full small-instance frame with per-frame pulse checks.
    task automatic s_frame(input int k);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk($sformatf("s_byte_rx_f%0d", k), 32'(s_byte_received), 32'd1);
        chk($sformatf("s_prep_early_f%0d", k), 32'(s_ack_prep), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk($sformatf("s_prep_f%0d", k), 32'(s_ack_prep), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk($sformatf("s_done_f%0d", k), 32'(s_ack_done), 32'd1);
    endtask

    initial begin
        // Reset state
        idle(2);
        rst = 1'b0;
        chk("rst_busy", 32'(d_busy), 32'd0);
        chk("rst_bidx", 32'(d_bit_index), 32'd0);
        chk("rst_bcnt", 32'(d_byte_count), 32'd0);
        chk("rst_chk_ack", 32'(d_check_ack), 32'd0);

        // IDLE ignores SCL edges
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_bidx", 32'(d_bit_index), 32'd0);
        chk("idle_busy", 32'(d_busy), 32'd0);

        // Default frame: data bits then the ACK bit
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_busy", 32'(d_busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("bidx_%0d", i + 1), 32'(d_bit_index), 32'(i + 1));
            if (i < 7) chk($sformatf("byte_rx_lo_%0d", i + 1), 32'(d_byte_received), 32'd0);
        end
        chk("byte_rx_hi", 32'(d_byte_received), 32'd1);
        chk("prep_before_fall", 32'(d_ack_prep), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ack_prep_pulse", 32'(d_ack_prep), 32'd1);
        chk("byte_rx_fall", 32'(d_byte_received), 32'd0);
        chk("check_ack_rise", 32'(d_check_ack), 32'd1);
        idle(1);
        chk("ack_prep_one", 32'(d_ack_prep), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ack_rise_ignored", 32'(d_check_ack), 32'd1);
        chk("ack_done_early", 32'(d_ack_done), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ack_done_pulse", 32'(d_ack_done), 32'd1);
        chk("check_ack_fall", 32'(d_check_ack), 32'd0);
        chk("bcnt_1", 32'(d_byte_count), 32'd1);
        chk("bidx_clr", 32'(d_bit_index), 32'd0);
        idle(1);
        chk("ack_done_one", 32'(d_ack_done), 32'd0);

        // Simultaneous edges are ignored
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_edges", 32'(d_bit_index), 32'd0);

        // Repeated START after bit 5
        mark = d_prep_cnt;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("bidx_5", 32'(d_bit_index), 32'd5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rs_busy", 32'(d_busy), 32'd1);
        chk("rs_bidx", 32'(d_bit_index), 32'd0);
        chk("rs_bcnt", 32'(d_byte_count), 32'd0);
        chk("rs_byte_rx", 32'(d_byte_received), 32'd0);
        idle(1);
        chk("rs_no_prep", 32'(d_prep_cnt - mark), 32'd0);

        // Small instance: three frames, then saturation of the 2-bit count
        mark = s_prep_cnt;
        for (int k = 1; k <= 3; k++) s_frame(k);
        chk("s_bcnt_3", 32'(s_byte_count), 32'd3);
        idle(1);
        chk("s_prep_cnt_3", 32'(s_prep_cnt - mark), 32'd3);
        for (int k = 4; k <= 5; k++) s_frame(k);
        chk("s_bcnt_sat", 32'(s_byte_count), 32'd3);

        // Timeout 20 cycles after the last SCL edge
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("to_bidx_2", 32'(s_bit_index), 32'd2);
        idle(19);
        chk("to_not_early", 32'(s_timeout), 32'd0);
        chk("to_busy_early", 32'(s_busy), 32'd1);
        idle(1);
        chk("to_pulse", 32'(s_timeout), 32'd1);
        chk("to_busy_lo", 32'(s_busy), 32'd0);
        chk("to_bidx_clr", 32'(s_bit_index), 32'd0);
        idle(1);
        chk("to_one_cycle", 32'(s_timeout), 32'd0);

        // START in the timeout cycle wins
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(19);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("to_start_wins", 32'(s_timeout), 32'd0);
        chk("to_start_busy", 32'(s_busy), 32'd1);
        chk("to_start_bidx", 32'(s_bit_index), 32'd0);
        idle(1);
        chk("to_start_none", 32'(s_timeout), 32'd0);

        // STOP returns to IDLE and keeps the byte count
        step(1'b0, 1'b0, 1'b1, 1'b0);
        d_frame();
        chk("d_bcnt_before_stop", 32'(d_byte_count), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("stop_busy", 32'(d_busy), 32'd0);
        chk("stop_bcnt_hold", 32'(d_byte_count), 32'd1);
        chk("stop_bidx", 32'(d_bit_index), 32'd0);

        // Reset while check_ack is high
        step(1'b0, 1'b0, 1'b1, 1'b0);
        d_frame();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_chk_ack", 32'(d_check_ack), 32'd1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mid_rst_chk_ack", 32'(d_check_ack), 32'd0);
        chk("mid_rst_busy", 32'(d_busy), 32'd0);
        chk("mid_rst_bcnt", 32'(d_byte_count), 32'd0);
        chk("mid_rst_bidx", 32'(d_bit_index), 32'd0);
        chk("mid_rst_byte_rx", 32'(d_byte_received), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_busy", 32'(d_busy), 32'd1);
        d_frame();
        chk("post_rst_bcnt", 32'(d_byte_count), 32'd1);
        chk("post_rst_bidx", 32'(d_bit_index), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
